// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR filter. One external signed 16x16 multiplier is shared
// across all taps. Each accepted sample costs NTAPS MAC cycles and one output cycle.
module fir_tap_sequencer #(
  parameter int unsigned NTAPS = 8,
  parameter int unsigned SHIFT = 15,
  parameter int unsigned ACC_W = 36
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic [15:0]                coef_data,
  output logic [15:0]                mac_a,
  output logic [15:0]                mac_b,
  input  logic [31:0]                mac_p,
  output logic [15:0]                y_out,
  output logic                       y_valid,
  output logic                       busy
);

  localparam int unsigned AW = $clog2(NTAPS);

  localparam logic signed [ACC_W-1:0] RoundK = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-16){1'b0}}, 16'h7fff};
  localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-16){1'b1}}, 16'h8000};

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StOut
  } state_e;

  state_e                   r_state;
  state_e                   w_state_next;

  logic [15:0]              r_buf  [NTAPS];
  logic [15:0]              r_coef [NTAPS];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_tap;
  logic signed [ACC_W-1:0]  r_acc;
  logic [15:0]              r_y_out;

  logic                     w_accept;
  logic                     w_coef_wr;
  logic                     w_last_tap;
  logic [AW:0]              w_rd_sum;
  logic [AW-1:0]            w_rd_idx;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [ACC_W-1:0]  w_rounded;
  logic signed [ACC_W-1:0]  w_shifted;
  logic [15:0]              w_sat;

  assign w_accept   = sample_valid && (r_state == StIdle);
  // Coefficient writes are dropped outright while a sample is in flight.
  assign w_coef_wr  = coef_we && (r_state == StIdle) && (32'(coef_addr) < NTAPS);
  assign w_last_tap = (r_tap == AW'(NTAPS - 1));

  // Buffer read index: (wr_ptr - tap) mod NTAPS, valid for non-power-of-two NTAPS too.
  always_comb begin
    w_rd_sum = {1'b0, r_wr_ptr} + (AW+1)'(NTAPS) - {1'b0, r_tap};
    w_rd_idx = AW'(w_rd_sum);
    if (w_rd_sum >= (AW+1)'(NTAPS)) begin
      w_rd_idx = AW'(w_rd_sum - (AW+1)'(NTAPS));
    end
  end

  // Accumulate, round half-up, arithmetic shift and clamp to 16 bits.
  always_comb begin
    w_prod_ext = {{(ACC_W-32){mac_p[31]}}, mac_p};
    w_acc_next = r_acc + w_prod_ext;
    w_rounded  = w_acc_next + RoundK;
    w_shifted  = w_rounded >>> SHIFT;
    if (w_shifted > SatMax) begin
      w_sat = 16'h7fff;
    end else if (w_shifted < SatMin) begin
      w_sat = 16'h8000;
    end else begin
      w_sat = w_shifted[15:0];
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    sample_ready = 1'b0;
    y_valid      = 1'b0;
    busy         = 1'b1;
    mac_a        = 16'h0000;
    mac_b        = 16'h0000;
    unique case (r_state)
      StIdle: begin
        sample_ready = 1'b1;
        busy         = 1'b0;
        if (w_accept) begin
          w_state_next = StMac;
        end
      end
      StMac: begin
        mac_a = r_buf[w_rd_idx];
        mac_b = r_coef[r_tap];
        if (w_last_tap) begin
          w_state_next = StOut;
        end
      end
      StOut: begin
        y_valid      = 1'b1;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign y_out = r_y_out;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Sample buffer, coefficient store, accumulator and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_tap    <= '0;
      r_acc    <= '0;
      r_y_out  <= 16'h0000;
      for (int i = 0; i < NTAPS; i++) begin
        r_buf[i]  <= 16'h0000;
        r_coef[i] <= 16'h0000;
      end
    end else begin
      if (w_coef_wr) begin
        r_coef[coef_addr] <= coef_data;
      end
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_buf[r_wr_ptr] <= sample_in;
            r_acc           <= '0;
            r_tap           <= '0;
          end
        end
        StMac: begin
          r_acc <= w_acc_next;
          r_tap <= r_tap + AW'(1);
          if (w_last_tap) begin
            r_y_out <= w_sat;
          end
        end
        StOut: begin
          r_wr_ptr <= (r_wr_ptr == AW'(NTAPS - 1)) ? '0 : r_wr_ptr + AW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with a queue-based output scoreboard.
module tb_fir_tap_sequencer;

  localparam int unsigned NTAPS = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = 16'h0000;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_addr = 3'd0;
  logic [15:0] coef_data = 16'h0000;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [31:0] mac_p;
  logic [15:0] y_out;
  logic        y_valid;
  logic        busy;

  logic signed [31:0] ext_a;
  logic signed [31:0] ext_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];
  int          due_q[$];

  fir_tap_sequencer #(
    .NTAPS(NTAPS),
    .SHIFT(15),
    .ACC_W(36)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .mac_a       (mac_a),
    .mac_b       (mac_b),
    .mac_p       (mac_p),
    .y_out       (y_out),
    .y_valid     (y_valid),
    .busy        (busy)
  );

  // External zero-latency signed multiplier.
  assign ext_a = {{16{mac_a[15]}}, mac_a};
  assign ext_b = {{16{mac_b[15]}}, mac_b};
  assign mac_p = ext_a * ext_b;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every y_valid pops one expected value and its due cycle.
  always @(negedge clk) begin
    if (!reset && y_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_y_valid: got y_out %h expected no output (cycle %0d)",
                 y_out, cyc);
      end else begin
        logic [15:0] e;
        int          d;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        chk("y_out", y_out, e);
        checks++;
        if (cyc != d) begin
          errors++;
          $display("FAIL y_valid_timing: got cycle %0d expected cycle %0d", cyc, d);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic load_coefs(input logic [15:0] c0, input logic [15:0] c1,
                            input logic [15:0] rest);
    for (int i = 0; i < NTAPS; i++) begin
      write_coef(3'(i), (i == 0) ? c0 : (i == 1) ? c1 : rest);
    end
  endtask

  // Waits for ready, issues one sample, optionally records the expected result.
  task automatic send(input logic [15:0] s, input logic [15:0] e, input bit expect_out);
    int n = 0;
    while (!sample_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!sample_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got sample_ready 0 expected 1 within 100 cycles");
    end else begin
      sample_in    = s;
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      if (expect_out) begin
        exp_q.push_back(e);
        due_q.push_back(cyc + NTAPS);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outputs pending expected 0", exp_q.size());
      exp_q.delete();
      due_q.delete();
    end
  endtask

  task automatic impulse();
    send(16'h7fff, 16'h4000, 1'b1);
    send(16'h0000, 16'h2000, 1'b1);
    send(16'h0000, 16'h0000, 1'b1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected $finish");
    $fatal(1);
  end

  initial begin
    int accepts;
    int lows;
    int last_e;
    bit r;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y_out", y_out, 16'h0000);
    chk("rst_y_valid", {15'd0, y_valid}, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'h0000);
    chk("rst_mac_a", mac_a, 16'h0000);
    chk("rst_mac_b", mac_b, 16'h0000);
    reset = 1'b0;
    chk("rst_ready", {15'd0, sample_ready}, 16'h0001);

    // Impulse response with operand checks on the first two taps
    load_coefs(16'h4000, 16'h2000, 16'h0000);
    send(16'h7fff, 16'h4000, 1'b1);
    chk("mac_a_tap0", mac_a, 16'h7fff);
    chk("mac_b_tap0", mac_b, 16'h4000);
    @(posedge clk);
    #1;
    chk("mac_a_tap1", mac_a, 16'h0000);
    chk("mac_b_tap1", mac_b, 16'h2000);
    chk("busy_mac", {15'd0, busy}, 16'h0001);
    chk("ready_mac", {15'd0, sample_ready}, 16'h0000);
    send(16'h0000, 16'h2000, 1'b1);
    send(16'h0000, 16'h0000, 1'b1);
    drain();
    chk("idle_mac_a", mac_a, 16'h0000);

    // Signed rounding, then output hold
    do_reset();
    load_coefs(16'h7fff, 16'h0000, 16'h0000);
    send(16'hfffb, 16'hfffb, 1'b1);
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("y_hold", y_out, 16'hfffb);

    // Positive and negative saturation
    do_reset();
    load_coefs(16'h7fff, 16'h7fff, 16'h7fff);
    for (int i = 0; i < 8; i++) send(16'h7fff, (i == 0) ? 16'h7ffe : 16'h7fff, 1'b1);
    drain();
    do_reset();
    load_coefs(16'h7fff, 16'h7fff, 16'h7fff);
    for (int i = 0; i < 8; i++) send(16'h8000, (i == 0) ? 16'h8001 : 16'h8000, 1'b1);
    drain();

    // Handshake: valid held for 50 cycles
    do_reset();
    load_coefs(16'h4000, 16'h0000, 16'h0000);
    accepts = 0;
    lows = 0;
    last_e = 0;
    sample_in = 16'h0200;
    sample_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      r = sample_ready;
      @(posedge clk);
      #1;
      if (r) begin
        accepts++;
        exp_q.push_back(16'h0100);
        due_q.push_back(cyc + NTAPS);
        if (accepts > 1) begin
          checks++;
          if (cyc - last_e != 10) begin
            errors++;
            $display("FAIL accept_spacing: got %0d expected 10", cyc - last_e);
          end
        end
        last_e = cyc;
      end else begin
        lows++;
      end
    end
    sample_valid = 1'b0;
    chk("accept_count", 16'(accepts), 16'd5);
    chk("ready_low_cycles", 16'(lows), 16'd45);
    drain();

    // Reset mid-MAC at tap 3 aborts without output and clears coefficients
    do_reset();
    load_coefs(16'h4000, 16'h2000, 16'h0000);
    send(16'h7fff, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_y_out", y_out, 16'h0000);
    chk("abort_ready", {15'd0, sample_ready}, 16'h0001);
    chk("abort_busy", {15'd0, busy}, 16'h0000);
    repeat (15) @(posedge clk);
    #1;
    send(16'h7fff, 16'h0000, 1'b1);
    drain();
    do_reset();
    load_coefs(16'h4000, 16'h2000, 16'h0000);
    impulse();

    // Coefficient write while busy is dropped, not deferred
    do_reset();
    load_coefs(16'h4000, 16'h0000, 16'h0000);
    send(16'h7fff, 16'h4000, 1'b1);
    @(posedge clk);
    #1;
    chk("busy_before_we", {15'd0, busy}, 16'h0001);
    write_coef(3'd0, 16'h7fff);
    send(16'h0000, 16'h0000, 1'b1);
    send(16'h7fff, 16'h4000, 1'b1);
    drain();

    // Coefficient write on the accept edge applies to that sample
    do_reset();
    load_coefs(16'h4000, 16'h0000, 16'h0000);
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'h2000;
    send(16'h7fff, 16'h2000, 1'b1);
    coef_we = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
